// File: rtl/hf_sub.sv
// Registered full subtractor with a bit-serial borrow chain; optional saturating
// borrow-event counter enabled by defining HF_SUB_STATS_EN.
module hf_sub #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             in_valid,
  input  logic             chain,
  output logic             diff,
  output logic             borrow,
  output logic             out_valid
`ifdef HF_SUB_STATS_EN
  ,
  output logic [CNT_W-1:0] borrow_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hf_sub: CNT_W must be at least 1");
  end

  logic diff_q, diff_d;
  logic borrow_q, borrow_d;
  logic valid_q;
  logic bin;
  logic diff_calc;
  logic borrow_calc;

  // The registered borrow output doubles as the chain state: both load the
  // computed borrow on every accepted input and both hold otherwise.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    bin         = chain ? borrow_q : c;
    diff_calc   = a ^ b ^ bin;
    borrow_calc = (~a & b) | (~(a ^ b) & bin);
    diff_d      = diff_q;
    borrow_d    = borrow_q;
    if (in_valid) begin
      diff_d   = diff_calc;
      borrow_d = borrow_calc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q   <= 1'b0;
      borrow_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      valid_q  <= in_valid;
    end
  end

  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign out_valid = valid_q;

`ifdef HF_SUB_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && borrow_calc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign borrow_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_hf_sub.sv
// Self-checking bench for hf_sub: table-driven vectors plus hand-written
// sequences for idle hold, asynchronous reset mid-chain, back-to-back and stats.
module tb_hf_sub;

  logic       clk;
  logic       rst_n;
  logic       a, b, c, in_valid, chain;
  logic       diff, borrow, out_valid;
`ifdef HF_SUB_STATS_EN
  logic [1:0] borrow_cnt;
`endif

  int checks = 0;
  int errors = 0;

  hf_sub #(.CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .in_valid  (in_valid),
    .chain     (chain),
    .diff      (diff),
    .borrow    (borrow),
    .out_valid (out_valid)
`ifdef HF_SUB_STATS_EN
    ,
    .borrow_cnt(borrow_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic a, b, c, chain, in_valid;
    logic exp_diff, exp_borrow, exp_ov;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ai, bi, ci, chi, vi);
    @(negedge clk);
    a = ai; b = bi; c = ci; chain = chi; in_valid = vi;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a = 1'b0; b = 1'b0; c = 1'b0; chain = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs[$];

  initial begin
    logic mb;
    int   t;
    logic ra, rb, rc, rch;
    logic ed, eb;

    rst_n = 1'b0;
    a = 1'b0; b = 1'b0; c = 1'b0; chain = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_diff", {7'd0, diff}, 8'd0);
    check("reset_borrow", {7'd0, borrow}, 8'd0);
    check("reset_out_valid", {7'd0, out_valid}, 8'd0);
`ifdef HF_SUB_STATS_EN
    check("reset_cnt", {6'd0, borrow_cnt}, 8'd0);
`endif
    rst_n = 1'b1;

    // a, b, c, chain, in_valid, diff, borrow, out_valid
    vecs = '{
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1},  // first chain after reset: bin=0
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1},  // truth table 000..111
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1},  // 0011 - 0101, LSB first
      '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1},
      '{1'bx, 1'bx, 1'bx, 1'bx, 1'b0, 1'b1, 1'b1, 1'b0},  // idle with X inputs: hold
      '{1'bx, 1'bx, 1'bx, 1'bx, 1'b0, 1'b1, 1'b1, 1'b0},
      '{1'bx, 1'bx, 1'bx, 1'bx, 1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1},  // held borrow survives idle, c ignored
      '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}   // chain=1 uses bin=0, not c=1
    };

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].chain, vecs[i].in_valid);
      check($sformatf("vec%0d_diff", i), {7'd0, diff}, {7'd0, vecs[i].exp_diff});
      check($sformatf("vec%0d_borrow", i), {7'd0, borrow}, {7'd0, vecs[i].exp_borrow});
      check($sformatf("vec%0d_out_valid", i), {7'd0, out_valid}, {7'd0, vecs[i].exp_ov});
    end

    // Asynchronous reset between edges while a borrow is pending.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("pre_rst_borrow", {7'd0, borrow}, 8'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_diff", {7'd0, diff}, 8'd0);
    check("async_rst_borrow", {7'd0, borrow}, 8'd0);
    check("async_rst_out_valid", {7'd0, out_valid}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("post_rst_chain_diff", {7'd0, diff}, 8'd0);
    check("post_rst_chain_borrow", {7'd0, borrow}, 8'd0);
    check("post_rst_chain_out_valid", {7'd0, out_valid}, 8'd1);

    // 16 back-to-back inputs against an arithmetic model of a - b - bin.
    mb = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      rch = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      t = int'(ra) - int'(rb) - int'(rch ? mb : rc);
      ed = (t % 2 != 0);
      eb = (t < 0);
      mb = eb;
      drive(ra, rb, rc, rch, 1'b1);
      check($sformatf("b2b%0d_diff", i), {7'd0, diff}, {7'd0, ed});
      check($sformatf("b2b%0d_borrow", i), {7'd0, borrow}, {7'd0, eb});
      check($sformatf("b2b%0d_out_valid", i), {7'd0, out_valid}, 8'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("b2b_end_out_valid", {7'd0, out_valid}, 8'd0);

`ifdef HF_SUB_STATS_EN
    do_reset();
    check("stats_after_reset", {6'd0, borrow_cnt}, 8'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check($sformatf("stats_cnt%0d", i), {6'd0, borrow_cnt}, (i < 3) ? 8'(i + 1) : 8'd3);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("stats_idle_hold", {6'd0, borrow_cnt}, 8'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hf_sub.md
HF_SUB -- requirements
Module: hf_sub

Interface
REQ-001 Parameter: CNT_W, default 8, width of the borrow-event counter.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 Port: a  input  1  minuend bit.
REQ-005 Port: b  input  1  subtrahend bit.
REQ-006 Port: c  input  1  external borrow-in bit.
REQ-007 Port: in_valid  input  1  qualifies a, b, c and chain for the current cycle.
REQ-008 Port: chain  input  1  1 = use the internally held borrow instead of c (bit-serial multi-bit subtraction, LSB first).
REQ-009 Port: diff  output  1  registered difference bit.
REQ-010 Port: borrow  output  1  registered borrow-out bit.
REQ-011 Port: out_valid  output  1  high for one cycle when diff/borrow hold a new result.
REQ-012 Port: borrow_cnt  output  CNT_W  count of results with borrow=1 (present only with HF_SUB_STATS_EN).

Function
REQ-013 Effective borrow-in bin SHALL be c when chain=0, and the internal borrow register when chain=1.
REQ-014 On a cycle with in_valid=1, the block SHALL register diff = a XOR b XOR bin.
REQ-015 On the same cycle, it SHALL register borrow = (NOT a AND b) OR (NOT (a XOR b) AND bin).
REQ-016 Latency SHALL be exactly 1 clock: the result appears on the rising edge that samples in_valid=1.
REQ-017 out_valid SHALL equal in_valid delayed by one cycle.
REQ-018 No backpressure: a new input may be accepted every cycle.
REQ-019 With in_valid=0, diff and borrow SHALL hold their last values, and the internal borrow register SHALL hold.
REQ-020 The internal borrow register SHALL load the computed borrow on every accepted input, regardless of chain.
REQ-021 chain=1 on the first accepted input after reset SHALL use bin=0.
REQ-022 X/undriven inputs with in_valid=0 SHALL NOT alter any state.

Reset
REQ-023 While rst_n=0: diff=0, borrow=0, out_valid=0, internal borrow=0, and borrow_cnt=0, all asynchronously.
REQ-024 Reset asserted mid-chain SHALL discard the pending borrow; the first accepted input after release computes from the reset state.
REQ-025 Release SHALL be synchronous-safe: the first capture occurs on the first rising clk edge with rst_n=1.

Configuration
REQ-026 Macro HF_SUB_STATS_EN defined: the borrow_cnt port and counter SHALL exist.
REQ-027 With HF_SUB_STATS_EN, the counter SHALL increment by 1 on each accepted input whose computed borrow=1.
REQ-028 The counter SHALL saturate at 2^CNT_W-1, with no wrap.
REQ-029 Macro HF_SUB_STATS_EN undefined: the borrow_cnt port and counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Truth table, chain=0, in_valid=1, one vector per cycle for abc=000,001,010,011,100,101,110,111 -> diff/borrow one cycle later = 0/0, 1/1, 1/1, 0/1, 1/0, 0/0, 0/0, 1/1, with out_valid=1 for each.
REQ-031 Serial 4-bit subtraction 0011-0101, LSB first, chain=0 on the first bit and chain=1 after -> diff bits 0,1,1,1 (1110), final borrow=1.
REQ-032 in_valid=0 for 3 cycles after result 1/1 -> diff=1, borrow=1 held, out_valid=0.
REQ-033 rst_n pulsed low asynchronously between clock edges mid-chain -> outputs go to 0 immediately; the next chained input a=0, b=0 yields diff=0, borrow=0.
REQ-034 HF_SUB_STATS_EN with CNT_W=2 and 5 borrowing inputs -> borrow_cnt reads 1, 2, 3, 3, 3.
REQ-035 Back-to-back inputs on every cycle for 16 cycles -> 16 consecutive out_valid pulses with matching results.
